// File: rtl/sm3_expnd_core.sv
// sm3_expnd_core
// SM3 message expansion. Loads one 512-bit block as 16 big-endian 32-bit words,
// then streams 64 rounds of W_j and W'_j = W_j ^ W_(j+4), one per cycle, to a
// downstream compression core. After the last round the block sits idle for
// BLK_GAP cycles before accepting the next block.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   msg_inpt_d_i      message word (word 0 of the block first)
//   msg_inpt_vld_i    word valid
//   msg_inpt_lst_i    block is the last of its message (sampled with word 15 only)
//   msg_inpt_rdy_o    word accepted when vld & rdy
//   expnd_otpt_wj_o   W_j
//   expnd_otpt_wjj_o  W'_j
//   expnd_otpt_vld_o  W_j / W'_j valid (no backpressure)
//   expnd_otpt_lst_o  round 63 of the last block of a message
module sm3_expnd_core #(
  parameter int BLK_WRD_NUM   = 16,
  parameter int EXPND_RND_NUM = 64,
  parameter int BLK_GAP       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] msg_inpt_d_i,
  input  logic        msg_inpt_vld_i,
  input  logic        msg_inpt_lst_i,
  output logic        msg_inpt_rdy_o,
  output logic [31:0] expnd_otpt_wj_o,
  output logic [31:0] expnd_otpt_wjj_o,
  output logic        expnd_otpt_vld_o,
  output logic        expnd_otpt_lst_o
);

  localparam int WCNT_W = $clog2(BLK_WRD_NUM);
  localparam int RCNT_W = $clog2(EXPND_RND_NUM);
  localparam int GCNT_W = (BLK_GAP > 1) ? $clog2(BLK_GAP) : 1;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BLK_WRD_NUM - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(EXPND_RND_NUM - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((BLK_GAP > 0) ? BLK_GAP - 1 : 0);
  localparam bit                HAS_GAP   = (BLK_GAP > 0);

  typedef enum logic [1:0] {
    LOAD,
    EXPAND,
    GAP
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wrd_cnt;
  logic [RCNT_W-1:0] rnd_cnt;
  logic [GCNT_W-1:0] gap_cnt;
  logic              last_flag;
  logic              rdy_q;
  logic              vld_q;
  logic              lst_q;
  logic [31:0]       wj_q;
  logic [31:0]       wjj_q;

  // win[k] holds W_(j+k) for the round j about to be emitted.
  logic [31:0] win [16];

  logic        xfer;
  logic        ld_shift;
  logic        exp_shift;
  logic [31:0] p1_in;
  logic [31:0] new_wrd;

  function automatic logic [31:0] rotl7(input logic [31:0] x);
    return {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] rotl15(input logic [31:0] x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic logic [31:0] rotl23(input logic [31:0] x);
    return {x[8:0], x[31:9]};
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl15(x) ^ rotl23(x);
  endfunction

  assign xfer      = rdy_q & msg_inpt_vld_i;
  assign ld_shift  = (state == LOAD) & xfer;
  assign exp_shift = (state == EXPAND);

  // W_(j+16) from the current window: W_j, W_(j+3), W_(j+7), W_(j+10), W_(j+13).
  assign p1_in   = win[0] ^ win[7] ^ rotl15(win[13]);
  assign new_wrd = p1(p1_in) ^ rotl7(win[3]) ^ win[10];

  // The window is a plain shift register fed by the input port while loading
  // and by the expansion recurrence while expanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (ld_shift || exp_shift) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= ld_shift ? msg_inpt_d_i : new_wrd;
    end
  end

  // Control FSM with registered outputs. Output registers default to zero so
  // data and lst are forced low whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wrd_cnt   <= '0;
      rnd_cnt   <= '0;
      gap_cnt   <= '0;
      last_flag <= 1'b0;
      rdy_q     <= 1'b1;
      vld_q     <= 1'b0;
      lst_q     <= 1'b0;
      wj_q      <= '0;
      wjj_q     <= '0;
    end else begin
      vld_q <= 1'b0;
      lst_q <= 1'b0;
      wj_q  <= '0;
      wjj_q <= '0;

      case (state)
        LOAD: begin
          if (xfer) begin
            if (wrd_cnt == WCNT_LAST) begin
              wrd_cnt   <= '0;
              last_flag <= msg_inpt_lst_i;
              rdy_q     <= 1'b0;
              state     <= EXPAND;
            end else begin
              wrd_cnt <= wrd_cnt + 1'b1;
            end
          end
        end

        EXPAND: begin
          vld_q <= 1'b1;
          wj_q  <= win[0];
          wjj_q <= win[0] ^ win[4];
          lst_q <= last_flag && (rnd_cnt == RCNT_LAST);
          if (rnd_cnt == RCNT_LAST) begin
            rnd_cnt   <= '0;
            last_flag <= 1'b0;
            if (HAS_GAP) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              rdy_q <= 1'b1;
              state <= LOAD;
            end
          end else begin
            rnd_cnt <= rnd_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GCNT_LAST) begin
            gap_cnt <= '0;
            rdy_q   <= 1'b1;
            state   <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          rdy_q <= 1'b1;
          state <= LOAD;
        end
      endcase
    end
  end

  assign msg_inpt_rdy_o   = rdy_q;
  assign expnd_otpt_vld_o = vld_q;
  assign expnd_otpt_lst_o = lst_q;
  assign expnd_otpt_wj_o  = wj_q;
  assign expnd_otpt_wjj_o = wjj_q;

endmodule

// File: tb/tb_sm3_expnd_core.sv
// tb_sm3_expnd_core
// Self-checking bench for sm3_expnd_core: golden "abc" vectors from a table,
// hand-written corner sequences (toggled load, held valid, resets) and random
// blocks checked against a software SM3 expansion model.
module tb_sm3_expnd_core;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] wexp_t [68];

  typedef struct {
    int          j;
    bit          chkWj;
    logic [31:0] expWj;
    bit          chkWjj;
    logic [31:0] expWjj;
    logic        expLst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] msg_inpt_d_i;
  logic        msg_inpt_vld_i;
  logic        msg_inpt_lst_i;
  logic        msg_inpt_rdy_o;
  logic [31:0] expnd_otpt_wj_o;
  logic [31:0] expnd_otpt_wjj_o;
  logic        expnd_otpt_vld_o;
  logic        expnd_otpt_lst_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] gotWj  [64];
  logic [31:0] gotWjj [64];
  logic        gotLst [64];

  vec_t abcTable [11];
  blk_t abcBlk;

  sm3_expnd_core #(
    .BLK_WRD_NUM  (16),
    .EXPND_RND_NUM(64),
    .BLK_GAP      (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .msg_inpt_d_i     (msg_inpt_d_i),
    .msg_inpt_vld_i   (msg_inpt_vld_i),
    .msg_inpt_lst_i   (msg_inpt_lst_i),
    .msg_inpt_rdy_o   (msg_inpt_rdy_o),
    .expnd_otpt_wj_o  (expnd_otpt_wj_o),
    .expnd_otpt_wjj_o (expnd_otpt_wjj_o),
    .expnd_otpt_vld_o (expnd_otpt_vld_o),
    .expnd_otpt_lst_o (expnd_otpt_lst_o)
  );

  always #5 clk = ~clk;

  // Reference model: textbook SM3 message expansion over a whole block.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[63-n -: 32];
  endfunction

  function automatic logic [31:0] modelP1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic void sm3Expand(input blk_t blk, output wexp_t w);
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 68; i++)
      w[i] = modelP1(w[i-16] ^ w[i-9] ^ rotl(w[i-3], 15)) ^ rotl(w[i-13], 7) ^ w[i-6];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one block; returns just after the edge that accepts word 15.
  task automatic applyStimulus(input blk_t blk, input logic lst, input bit toggle);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < 16) begin
      @(negedge clk);
      if (toggle && ($urandom_range(0, 1) == 1)) begin
        msg_inpt_vld_i = 1'b0;
        msg_inpt_d_i   = $urandom;
        msg_inpt_lst_i = 1'($urandom_range(0, 1));
      end else begin
        msg_inpt_vld_i = 1'b1;
        msg_inpt_d_i   = blk[sent];
        msg_inpt_lst_i = (sent == 15) ? lst : 1'($urandom_range(0, 1));
        if (msg_inpt_rdy_o === 1'b1) sent++;
      end
      guard++;
      if (guard > 500) begin
        checkOutput("load_timeout", 32'(sent), 32'd16);
        msg_inpt_vld_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
  endtask

  // Observe the 64 rounds and the gap; optionally pulse reset after round abortAt.
  task automatic collectBlock(input blk_t blk, input logic lst, input bit holdVld,
                              input logic [31:0] holdWord, input int abortAt);
    wexp_t w;
    sm3Expand(blk, w);
    @(negedge clk);
    msg_inpt_vld_i = holdVld;
    msg_inpt_d_i   = holdWord;
    msg_inpt_lst_i = 1'b0;
    checkOutput("vld_before_w0", 32'(expnd_otpt_vld_o), 32'd0);
    checkOutput("rdy_after_load", 32'(msg_inpt_rdy_o), 32'd0);
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      gotWj[j]  = expnd_otpt_wj_o;
      gotWjj[j] = expnd_otpt_wjj_o;
      gotLst[j] = expnd_otpt_lst_o;
      checkOutput($sformatf("vld[%0d]", j), 32'(expnd_otpt_vld_o), 32'd1);
      checkOutput($sformatf("wj[%0d]", j), expnd_otpt_wj_o, w[j]);
      checkOutput($sformatf("wjj[%0d]", j), expnd_otpt_wjj_o, w[j] ^ w[j+4]);
      checkOutput($sformatf("lst[%0d]", j), 32'(expnd_otpt_lst_o), 32'((j == 63) && lst));
      if (j == abortAt) begin
        msg_inpt_vld_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_vld", 32'(expnd_otpt_vld_o), 32'd0);
        checkOutput("rst_wj", expnd_otpt_wj_o, 32'd0);
        checkOutput("rst_rdy", 32'(msg_inpt_rdy_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    checkOutput("gap0_vld", 32'(expnd_otpt_vld_o), 32'd0);
    checkOutput("gap0_rdy", 32'(msg_inpt_rdy_o), 32'd0);
    checkOutput("gap0_wj", expnd_otpt_wj_o, 32'd0);
    checkOutput("gap0_wjj", expnd_otpt_wjj_o, 32'd0);
    checkOutput("gap0_lst", 32'(expnd_otpt_lst_o), 32'd0);
    @(negedge clk);
    checkOutput("gap1_vld", 32'(expnd_otpt_vld_o), 32'd0);
    checkOutput("gap1_rdy", 32'(msg_inpt_rdy_o), 32'd1);
    msg_inpt_vld_i = 1'b0;
  endtask

  task automatic checkAbcTable(input string tag);
    for (int i = 0; i < 11; i++) begin
      if (abcTable[i].chkWj)
        checkOutput($sformatf("%s_tbl_wj[%0d]", tag, abcTable[i].j), gotWj[abcTable[i].j], abcTable[i].expWj);
      if (abcTable[i].chkWjj)
        checkOutput($sformatf("%s_tbl_wjj[%0d]", tag, abcTable[i].j), gotWjj[abcTable[i].j], abcTable[i].expWjj);
      checkOutput($sformatf("%s_tbl_lst[%0d]", tag, abcTable[i].j), 32'(gotLst[abcTable[i].j]), 32'(abcTable[i].expLst));
    end
  endtask

  function automatic void randBlock(output blk_t b);
    for (int i = 0; i < 16; i++) b[i] = $urandom;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    blk_t blkA;
    blk_t blkB;
    logic lst;

    abcTable[0]  = '{0,  1'b1, 32'h61626380, 1'b1, 32'h61626380, 1'b0};
    abcTable[1]  = '{1,  1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
    abcTable[2]  = '{12, 1'b1, 32'h00000000, 1'b1, 32'h9092e200, 1'b0};
    abcTable[3]  = '{13, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
    abcTable[4]  = '{14, 1'b1, 32'h00000000, 1'b1, 32'h000c0606, 1'b0};
    abcTable[5]  = '{15, 1'b1, 32'h00000018, 1'b0, 32'h0,        1'b0};
    abcTable[6]  = '{16, 1'b1, 32'h9092e200, 1'b0, 32'h0,        1'b0};
    abcTable[7]  = '{17, 1'b1, 32'h00000000, 1'b0, 32'h0,        1'b0};
    abcTable[8]  = '{18, 1'b1, 32'h000c0606, 1'b0, 32'h0,        1'b0};
    abcTable[9]  = '{62, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    abcTable[10] = '{63, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};

    for (int i = 0; i < 16; i++) abcBlk[i] = 32'h0;
    abcBlk[0]  = 32'h61626380;
    abcBlk[15] = 32'h00000018;

    rst_n          = 1'b0;
    msg_inpt_d_i   = 32'h0;
    msg_inpt_vld_i = 1'b0;
    msg_inpt_lst_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vld", 32'(expnd_otpt_vld_o), 32'd0);
    checkOutput("reset_wj", expnd_otpt_wj_o, 32'd0);
    checkOutput("reset_wjj", expnd_otpt_wjj_o, 32'd0);
    checkOutput("reset_lst", 32'(expnd_otpt_lst_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_rdy", 32'(msg_inpt_rdy_o), 32'd1);
    checkOutput("idle_vld", 32'(expnd_otpt_vld_o), 32'd0);

    // Golden "abc" block, contiguous and then with toggling valid.
    applyStimulus(abcBlk, 1'b1, 1'b0);
    collectBlock(abcBlk, 1'b1, 1'b0, 32'h0, -1);
    checkAbcTable("abc");
    applyStimulus(abcBlk, 1'b1, 1'b1);
    collectBlock(abcBlk, 1'b1, 1'b0, 32'h0, -1);
    checkAbcTable("abc_tgl");

    // Two-block message with valid held high through expand and gap.
    randBlock(blkA);
    randBlock(blkB);
    applyStimulus(blkA, 1'b0, 1'b0);
    collectBlock(blkA, 1'b0, 1'b1, blkB[0], -1);
    applyStimulus(blkB, 1'b1, 1'b0);
    collectBlock(blkB, 1'b1, 1'b0, 32'h0, -1);

    // Reset at round 30, then a fresh block.
    randBlock(blkA);
    applyStimulus(blkA, 1'b1, 1'b0);
    collectBlock(blkA, 1'b1, 1'b0, 32'h0, 30);
    randBlock(blkB);
    applyStimulus(blkB, 1'b0, 1'b0);
    collectBlock(blkB, 1'b0, 1'b0, 32'h0, -1);

    // Reset part way through a load; the partial words must be discarded.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      msg_inpt_vld_i = 1'b1;
      msg_inpt_d_i   = $urandom;
    end
    @(negedge clk);
    msg_inpt_vld_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midload_rst_rdy", 32'(msg_inpt_rdy_o), 32'd1);
    checkOutput("midload_rst_vld", 32'(expnd_otpt_vld_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    randBlock(blkA);
    applyStimulus(blkA, 1'b1, 1'b0);
    collectBlock(blkA, 1'b1, 1'b0, 32'h0, -1);

    // Random blocks, random last flag and random load pacing.
    for (int b = 0; b < 6; b++) begin
      randBlock(blkA);
      lst = 1'($urandom_range(0, 1));
      applyStimulus(blkA, lst, 1'($urandom_range(0, 1)));
      collectBlock(blkA, lst, 1'b0, 32'h0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sm3_expnd_core.md
SM3_EXPND_CORE -- requirements
Module: sm3_expnd_core

Interface
REQ-001 SHALL have parameter BLK_WRD_NUM, default 16, meaning message words per 512-bit block (fixed; other values unsupported).
REQ-002 SHALL have parameter EXPND_RND_NUM, default 64, meaning output rounds per block.
REQ-003 SHALL have parameter BLK_GAP, default 2, meaning minimum idle output cycles after each block.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 msg_inpt_d_i  input  32  padded message word, big-endian word order within block.
REQ-007 msg_inpt_vld_i  input  1  word valid.
REQ-008 msg_inpt_lst_i  input  1  block is last of message; sampled only with 16th word.
REQ-009 msg_inpt_rdy_o  output  1  block accepts a word; transfer = vld & rdy.
REQ-010 expnd_otpt_wj_o  output  32  W_j.
REQ-011 expnd_otpt_wjj_o  output  32  W'_j = W_j ^ W_(j+4).
REQ-012 expnd_otpt_vld_o  output  1  W_j/W'_j valid; no backpressure accepted.
REQ-013 expnd_otpt_lst_o  output  1  high with j=63 of last block only.

Function
REQ-014 States SHALL be LOAD, EXPAND, GAP; no other state reachable.
REQ-015 LOAD: rdy_o=1; each transfer shifts word into 16x32 window, word counter +1; input vld low holds counter/window.
REQ-016 Transfer with word counter=15 SHALL capture msg_inpt_lst_i into last flag, clear counter, go to EXPAND; lst on words 0..14 ignored.
REQ-017 EXPAND: rdy_o=0; round counter j 0..63; every cycle output registers load wj=win[0], wjj=win[0]^win[4], vld=1.
REQ-018 Window SHALL shift each EXPAND cycle, appending P1(win[0]^win[7]^(win[13]<<<15))^(win[3]<<<7)^win[10], P1(x)=x^(x<<<15)^(x<<<23), <<< 32-bit rotate.
REQ-019 Arithmetic SHALL be 32-bit XOR/rotate only; no carries.
REQ-020 Latency: 16th word accepted at edge k -> vld_o high after edges k+1..k+64 exactly (64 contiguous cycles, W0 first).
REQ-021 lst_o SHALL be 1 only in cycle carrying j=63 when last flag set; last flag cleared on leaving EXPAND.
REQ-022 After j=63, GAP SHALL last BLK_GAP cycles with vld_o=0, rdy_o=0, then LOAD; earliest next transfer at edge k+67.
REQ-023 When vld_o=0, wj_o, wjj_o, lst_o SHALL be 0.
REQ-024 Input vld asserted while rdy_o=0 SHALL be ignored (not consumed, no state change).
REQ-025 Downstream compression SHALL need no gap beyond REQ-022; consecutive blocks of one message reuse LOAD/EXPAND/GAP identically.

Reset
REQ-026 On rst_n low, asynchronously: state=LOAD, counters=0, last flag=0, window=0, rdy_o=1 after release, vld_o=0, lst_o=0, wj_o=0, wjj_o=0.
REQ-027 Reset mid-LOAD or mid-EXPAND SHALL discard partial block; no output until a full new 16-word block is loaded.

Verification
REQ-028 "abc" block 61626380,0x00000000x14,00000018, lst=1 -> W0=61626380, W'0=61626380, W16=9092e200, lst_o only at j=63; with compression core, hash 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
REQ-029 Input vld toggling 1/0 during load -> same 64 outputs as contiguous load; vld_o 64 contiguous cycles starting one cycle after 16th transfer.
REQ-030 Two-block message (lst=0 then lst=1) -> 128 valid cycles, gap >=2 between blocks, lst_o exactly once at final j=63.
REQ-031 vld_i held high through EXPAND/GAP -> no words consumed; rdy_o low 66 cycles; 17th word accepted only at edge k+67.
REQ-032 rst_n pulsed low at j=30 -> vld_o=0 immediately, rdy_o=1; next full block produces golden-model-correct W/W'.
REQ-033 Random blocks vs software SM3 expansion model -> all W_j, W'_j bit-exact.
